// File: rtl/oled_spi_responder.sv
// SSD1306-style SPI slave: deserialises bytes from an OLED SPI bus, decodes panel commands
// and stores data bytes in a local GDDRAM image with an external synchronous read port.
//
// state    | meaning
// CMD_IDLE | waiting for a command opcode
// CMD_ARG1 | opcode held, waiting for first argument
// CMD_ARG2 | two-argument opcode, waiting for second argument
module oled_spi_responder #(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       sdin,
  input  logic       cs,
  input  logic       cmd,
  input  logic [2:0] rd_page,
  input  logic [6:0] rd_col,
  output logic [7:0] rd_data,
  output logic [7:0] contrast,
  output logic       display_on,
  output logic       entire_on,
  output logic       invert,
  output logic       charge_pump,
  output logic [1:0] addr_mode,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_is_data,
  output logic       frame_wrap,
  output logic       framing_err
);

  localparam int DEPTH = COLS * PAGES;
  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);

  typedef enum logic [1:0] {CMD_IDLE, CMD_ARG1, CMD_ARG2} cmd_state_t;

  logic [1:0] sclk_sync, sdin_sync, cs_sync, cmd_sync;
  logic       sclk_prev, cs_prev;
  logic       sclk_rise, cs_rise;
  logic [6:0] shift_q;
  logic [2:0] bit_cnt;

  cmd_state_t state_q, state_d;
  logic [7:0] op_q;
  logic [6:0] arg1_q;

  logic       set_display, set_entire, set_invert;
  logic       ld_contrast, ld_pump, ld_mode, ld_col, ld_page, do_write;

  logic [6:0] col_start, col_end, col_ptr, col_nxt;
  logic [2:0] page_start, page_end, page_ptr, page_nxt;
  logic       wrap_nxt;

  logic [7:0]    gddram [DEPTH];
  logic [AW-1:0] wr_addr, rd_addr;

  // Two-flop synchronisers; cs idles high so no false rising edge leaves reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      sdin_sync <= '0;
      cs_sync   <= 2'b11;
      cmd_sync  <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      sdin_sync <= {sdin_sync[0], sdin};
      cs_sync   <= {cs_sync[0], cs};
      cmd_sync  <= {cmd_sync[0], cmd};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign cs_rise   = cs_sync[1] & ~cs_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q      <= '0;
      bit_cnt      <= '0;
      byte_valid   <= 1'b0;
      byte_out     <= '0;
      byte_is_data <= 1'b0;
      framing_err  <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      if (cs_rise) begin
        if (bit_cnt != 3'd0) framing_err <= 1'b1;
        bit_cnt <= '0;
      end else if (sclk_rise && !cs_sync[1]) begin
        shift_q <= {shift_q[5:0], sdin_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid   <= 1'b1;
          byte_out     <= {shift_q, sdin_sync[1]};
          byte_is_data <= cmd_sync[1];
        end
      end
    end
  end

  function automatic logic takes_arg(input logic [7:0] b);
    return b inside {8'h81, 8'h8D, 8'h20, 8'h21, 8'h22};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CMD_IDLE;
      op_q    <= '0;
      arg1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (byte_valid && !byte_is_data) begin
        if (state_q == CMD_IDLE) op_q <= byte_out;
        if (state_q == CMD_ARG1) arg1_q <= byte_out[6:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (byte_valid) begin
      if (byte_is_data) begin
        state_d = CMD_IDLE;
      end else begin
        case (state_q)
          CMD_IDLE: if (takes_arg(byte_out)) state_d = CMD_ARG1;
          CMD_ARG1: state_d = (op_q == 8'h21 || op_q == 8'h22) ? CMD_ARG2 : CMD_IDLE;
          default:  state_d = CMD_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    set_display = 1'b0;
    set_entire  = 1'b0;
    set_invert  = 1'b0;
    ld_contrast = 1'b0;
    ld_pump     = 1'b0;
    ld_mode     = 1'b0;
    ld_col      = 1'b0;
    ld_page     = 1'b0;
    do_write    = 1'b0;
    if (byte_valid) begin
      if (byte_is_data) begin
        do_write = 1'b1;
      end else begin
        case (state_q)
          CMD_IDLE: begin
            case (byte_out)
              8'hAE, 8'hAF: set_display = 1'b1;
              8'hA4, 8'hA5: set_entire  = 1'b1;
              8'hA6, 8'hA7: set_invert  = 1'b1;
              default: ;
            endcase
          end
          CMD_ARG1: begin
            case (op_q)
              8'h81:   ld_contrast = 1'b1;
              8'h8D:   ld_pump     = 1'b1;
              8'h20:   ld_mode     = (byte_out[1:0] != 2'b11);
              default: ;
            endcase
          end
          CMD_ARG2: begin
            ld_col  = (op_q == 8'h21);
            ld_page = (op_q == 8'h22);
          end
          default: ;
        endcase
      end
    end
  end

  // Pointer advance after a data write; mode 3 is never loaded, so it behaves as page mode.
  always_comb begin
    col_nxt  = col_ptr;
    page_nxt = page_ptr;
    wrap_nxt = 1'b0;
    case (addr_mode)
      2'd0: begin
        if (col_ptr == col_end) begin
          col_nxt = col_start;
          if (page_ptr == page_end) begin
            page_nxt = page_start;
            wrap_nxt = 1'b1;
          end else begin
            page_nxt = page_ptr + 3'd1;
          end
        end else begin
          col_nxt = col_ptr + 7'd1;
        end
      end
      2'd1: begin
        if (page_ptr == page_end) begin
          page_nxt = page_start;
          if (col_ptr == col_end) begin
            col_nxt  = col_start;
            wrap_nxt = 1'b1;
          end else begin
            col_nxt = col_ptr + 7'd1;
          end
        end else begin
          page_nxt = page_ptr + 3'd1;
        end
      end
      default: begin
        col_nxt = (col_ptr == col_end) ? col_start : col_ptr + 7'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contrast    <= 8'h7F;
      display_on  <= 1'b0;
      entire_on   <= 1'b0;
      invert      <= 1'b0;
      charge_pump <= 1'b0;
      addr_mode   <= 2'd2;
      col_start   <= '0;
      col_end     <= COL_LAST;
      page_start  <= '0;
      page_end    <= PAGE_LAST;
      col_ptr     <= '0;
      page_ptr    <= '0;
      frame_wrap  <= 1'b0;
    end else begin
      frame_wrap <= 1'b0;
      if (set_display) display_on  <= byte_out[0];
      if (set_entire)  entire_on   <= byte_out[0];
      if (set_invert)  invert      <= byte_out[0];
      if (ld_contrast) contrast    <= byte_out;
      if (ld_pump)     charge_pump <= byte_out[2];
      if (ld_mode)     addr_mode   <= byte_out[1:0];
      if (ld_col) begin
        col_start <= arg1_q;
        col_end   <= byte_out[6:0];
        col_ptr   <= arg1_q;
      end
      if (ld_page) begin
        page_start <= arg1_q[2:0];
        page_end   <= byte_out[2:0];
        page_ptr   <= arg1_q[2:0];
      end
      if (do_write) begin
        col_ptr    <= col_nxt;
        page_ptr   <= page_nxt;
        frame_wrap <= wrap_nxt;
      end
    end
  end

  assign wr_addr = AW'(page_ptr) * AW'(COLS) + AW'(col_ptr);
  assign rd_addr = AW'(rd_page) * AW'(COLS) + AW'(rd_col);

  // Display memory is deliberately not reset; read-before-write gives old data on collision.
  always_ff @(posedge clk) begin
    if (do_write) gddram[wr_addr] <= byte_out;
    rd_data <= gddram[rd_addr];
  end

endmodule

// File: tb/tb_oled_spi_responder.sv
// Directed bench for oled_spi_responder: drives SPI bytes, checks decoded state,
// strobe counts and GDDRAM contents against hand-computed values.
`timescale 1ns/100ps
module tb_oled_spi_responder;
  logic       clk = 1'b0;
  logic       reset;
  logic       sclk, sdin, cs, cmd;
  logic [2:0] rd_page;
  logic [6:0] rd_col;
  logic [7:0] rd_data, contrast, byte_out;
  logic       display_on, entire_on, invert, charge_pump;
  logic [1:0] addr_mode;
  logic       byte_valid, byte_is_data, frame_wrap, framing_err;

  int n_checks = 0;
  int n_fail = 0;
  int n_bv = 0, n_data = 0, n_cmd = 0, n_fw = 0, n_fe = 0, wrap_at = -1;
  logic [7:0] last_byte = 8'h00;
  logic       last_dc = 1'b0;
  int base_data, base_fw, base_bv, base_fe, base_cmd;

  oled_spi_responder #(.COLS(128), .PAGES(8)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .sdin(sdin), .cs(cs), .cmd(cmd),
    .rd_page(rd_page), .rd_col(rd_col), .rd_data(rd_data),
    .contrast(contrast), .display_on(display_on), .entire_on(entire_on),
    .invert(invert), .charge_pump(charge_pump), .addr_mode(addr_mode),
    .byte_valid(byte_valid), .byte_out(byte_out), .byte_is_data(byte_is_data),
    .frame_wrap(frame_wrap), .framing_err(framing_err)
  );

  always #18.5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) begin
      n_bv++;
      last_byte = byte_out;
      last_dc = byte_is_data;
      if (byte_is_data) n_data++;
      else n_cmd++;
    end
    if (frame_wrap) begin
      n_fw++;
      wrap_at = n_data;
    end
    if (framing_err) n_fe++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_send(input logic [7:0] b, input logic dc, input int nbits,
                          input int half, input bit raise_cs);
    @(negedge clk);
    cs = 1'b0;
    cmd = dc;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      sdin = b[7-i];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    if (raise_cs) begin
      cs = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic cmd_byte(input logic [7:0] b);
    spi_send(b, 1'b0, 8, 3, 1'b1);
  endtask

  task automatic data_byte(input logic [7:0] b);
    spi_send(b, 1'b1, 8, 1, 1'b1);
  endtask

  task automatic rd_check(input string tag, input int p, input int c, input logic [7:0] exp);
    @(negedge clk);
    rd_page = 3'(p);
    rd_col = 7'(c);
    @(negedge clk);
    check(tag, rd_data, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_contrast"}, contrast, 8'h7F);
    check({tag, "_display"}, display_on, 1'b0);
    check({tag, "_entire"}, entire_on, 1'b0);
    check({tag, "_invert"}, invert, 1'b0);
    check({tag, "_pump"}, charge_pump, 1'b0);
    check({tag, "_mode"}, addr_mode, 2'd2);
    check({tag, "_bv"}, byte_valid, 1'b0);
    check({tag, "_fw"}, frame_wrap, 1'b0);
    check({tag, "_fe"}, framing_err, 1'b0);
  endtask

  initial begin
    logic [7:0] init_seq [10];
    init_seq = '{8'hAE, 8'h20, 8'h00, 8'h81, 8'h7F, 8'hA6, 8'hA4, 8'h8D, 8'h14, 8'hAF};
    reset = 1'b0;
    sclk = 1'b0; sdin = 1'b0; cs = 1'b1; cmd = 1'b0;
    rd_page = '0; rd_col = '0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // init command stream
    base_bv = n_bv; base_data = n_data;
    foreach (init_seq[k]) cmd_byte(init_seq[k]);
    check("init_display", display_on, 1'b1);
    check("init_mode", addr_mode, 2'd0);
    check("init_contrast", contrast, 8'h7F);
    check("init_pump", charge_pump, 1'b1);
    check("init_nbv", n_bv - base_bv, 10);
    check("init_ndata", n_data - base_data, 0);
    check("init_last", last_byte, 8'hAF);
    check("init_dc", last_dc, 1'b0);
    cmd_byte(8'h81); cmd_byte(8'h3C);
    check("contrast_3c", contrast, 8'h3C);

    // full-frame horizontal fill at sclk = clk/2
    base_fw = n_fw; base_data = n_data;
    for (int i = 0; i < 1024; i++) data_byte(8'(i));
    check("h_nfw", n_fw - base_fw, 1);
    check("h_wrap_at", wrap_at - base_data, 1024);
    check("h_dc", last_dc, 1'b1);
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 128; c++)
        rd_check($sformatf("hmem_%0d_%0d", p, c), p, c, 8'(p * 128 + c));

    // windowed horizontal writes
    cmd_byte(8'h21); cmd_byte(8'd10); cmd_byte(8'd12);
    cmd_byte(8'h22); cmd_byte(8'd2); cmd_byte(8'd3);
    base_fw = n_fw; base_data = n_data;
    for (int k = 0; k < 7; k++) data_byte(8'hC0 + 8'(k));
    check("win_nfw", n_fw - base_fw, 1);
    check("win_wrap_at", wrap_at - base_data, 6);
    rd_check("win_2_10", 2, 10, 8'hC6);
    rd_check("win_2_11", 2, 11, 8'hC1);
    rd_check("win_2_12", 2, 12, 8'hC2);
    rd_check("win_3_10", 3, 10, 8'hC3);
    rd_check("win_3_11", 3, 11, 8'hC4);
    rd_check("win_3_12", 3, 12, 8'hC5);
    rd_check("win_2_13", 2, 13, 8'h0D);

    // vertical mode
    cmd_byte(8'h20); cmd_byte(8'h01);
    check("v_mode", addr_mode, 2'd1);
    cmd_byte(8'h21); cmd_byte(8'd10); cmd_byte(8'd11);
    cmd_byte(8'h22); cmd_byte(8'd2); cmd_byte(8'd3);
    base_fw = n_fw; base_data = n_data;
    for (int k = 0; k < 4; k++) data_byte(8'hD0 + 8'(k));
    check("v_nfw", n_fw - base_fw, 1);
    check("v_wrap_at", wrap_at - base_data, 4);
    rd_check("v_2_10", 2, 10, 8'hD0);
    rd_check("v_3_10", 3, 10, 8'hD1);
    rd_check("v_2_11", 2, 11, 8'hD2);
    rd_check("v_3_11", 3, 11, 8'hD3);
    rd_check("v_2_12", 2, 12, 8'hC2);

    // page mode: column wraps, page stays, no frame_wrap
    cmd_byte(8'h20); cmd_byte(8'h02);
    cmd_byte(8'h21); cmd_byte(8'd20); cmd_byte(8'd21);
    cmd_byte(8'h22); cmd_byte(8'd5); cmd_byte(8'd5);
    base_fw = n_fw;
    for (int k = 0; k < 3; k++) data_byte(8'hE0 + 8'(k));
    check("p_nfw", n_fw - base_fw, 0);
    rd_check("p_5_20", 5, 20, 8'hE2);
    rd_check("p_5_21", 5, 21, 8'hE1);
    rd_check("p_6_20", 6, 20, 8'h14);
    cmd_byte(8'h20); cmd_byte(8'h03);
    check("mode3_ignored", addr_mode, 2'd2);

    // framing error on partial byte, then clean byte
    base_bv = n_bv; base_fe = n_fe;
    spi_send(8'hFF, 1'b0, 5, 3, 1'b1);
    check("fe_count", n_fe - base_fe, 1);
    check("fe_no_bv", n_bv - base_bv, 0);
    cmd_byte(8'hA7);
    check("fe_next_byte", last_byte, 8'hA7);
    check("fe_invert", invert, 1'b1);
    cmd_byte(8'hA5);
    check("entire_on", entire_on, 1'b1);

    // data byte abandons pending 0x81
    cmd_byte(8'h81);
    data_byte(8'h55);
    check("abandon_contrast", contrast, 8'h3C);
    rd_check("abandon_mem", 5, 21, 8'h55);
    cmd_byte(8'hAE);
    check("abandon_idle", display_on, 1'b0);
    cmd_byte(8'hAF);

    // reset mid-byte with 0x20 pending
    base_fe = n_fe;
    cmd_byte(8'h20);
    spi_send(8'hA0, 1'b0, 3, 3, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("midrst");
    cs = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_fe", n_fe - base_fe, 0);
    base_bv = n_bv;
    cmd_byte(8'h02);
    cmd_byte(8'hAF);
    check("midrst_nbv", n_bv - base_bv, 2);
    check("midrst_display", display_on, 1'b1);
    check("midrst_mode", addr_mode, 2'd2);

    // reset with 0x81 pending: argument slot must be discarded
    cmd_byte(8'h81);
    spi_send(8'h00, 1'b0, 4, 3, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    cmd_byte(8'h02);
    check("rst81_contrast", contrast, 8'h7F);
    rd_check("mem_kept", 5, 21, 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
